video_timing_gen: RTL and testbench

Parametrised raster timing generator for the frame-buffer display path. Produces hsync/vsync, an active-video flag, and pixel coordinates (full and down-scaled) for any timing that fits the configured widths, from a single clock with a pixel-rate clock enable. Feeds the frame-buffer read side and the video output stage. With the optional fetch-lead port set, the frame buffer can issue reads ahead of display.

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_timing_gen_axis.sv | 74 +++++++
 rtl/video_timing_gen.sv | 192 +++++++++++++++++++
 tb/tb_video_timing_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared definitions for the raster timing generator:
//   - axis_timing_t : one axis' sync / back porch / active / front porch lengths
//   - VGA_H, VGA_V  : default 640x480@60 timing (800 x 525 totals)
//   - axis_total()  : total count of one axis
//   - clog2_total() : bits needed to hold total-1, used for counter width checks
package video_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_timing_t;

  localparam axis_timing_t VGA_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
  localparam axis_timing_t VGA_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

  function automatic int axis_total(input axis_timing_t t);
    return int'(t.sync) + int'(t.bp) + int'(t.active) + int'(t.fp);
  endfunction

  function automatic int clog2_total(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis
// One raster axis: a wrap counter 0..TOTAL-1 that steps on adv, plus a
// decode of the counter's NEXT value so the parent can register outputs that
// line up with the counter in the same cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   adv           : advance the counter this cycle
//   at_end        : counter currently at TOTAL-1 (wraps on next advance)
//   sync_d        : next count lies in the sync interval
//   act_d         : next count lies in the active interval
//   coord_d       : next count minus active start, 0 outside active
//   lead_act_d    : active decode of (next count + LEAD), no wrap
//   lead_coord_d  : coordinate of (next count + LEAD), 0 outside active
module timing_axis import video_timing_pkg::*; #(
  parameter axis_timing_t TIM  = VGA_H,
  parameter int           CW   = 11,
  parameter int           LEAD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic          at_end,
  output logic          sync_d,
  output logic          act_d,
  output logic [CW-1:0] coord_d,
  output logic          lead_act_d,
  output logic [CW-1:0] lead_coord_d
);

  localparam int TOTAL = axis_total(TIM);
  localparam int START = int'(TIM.sync) + int'(TIM.bp);
  localparam int STOP  = START + int'(TIM.active);

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  // One extra bit so an active interval ending exactly at 2^CW still compares.
  localparam logic [CW:0]   SYNC_W  = (CW+1)'(int'(TIM.sync));
  localparam logic [CW:0]   START_W = (CW+1)'(START);
  localparam logic [CW:0]   STOP_W  = (CW+1)'(STOP);
  localparam logic [CW:0]   LEAD_W  = (CW+1)'(LEAD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW:0]   cnt_w;
  logic [CW:0]   lead_w;

  assign at_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = at_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_w   = {1'b0, cnt_d};
  assign sync_d  = (cnt_w < SYNC_W);
  assign act_d   = (cnt_w >= START_W) && (cnt_w < STOP_W);
  assign coord_d = act_d ? CW'(cnt_w - START_W) : '0;

  // The lead position is not wrapped: past the end of the line it simply
  // decodes as inactive, which matches the blanking it would land in.
  assign lead_w       = cnt_w + LEAD_W;
  assign lead_act_d   = (lead_w >= START_W) && (lead_w < STOP_W);
  assign lead_coord_d = lead_act_d ? CW'(lead_w - START_W) : '0;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator: hsync/vsync, active flag, pixel coordinates (full
// and down-scaled) and line/frame wrap pulses, advancing on pix_en.
// Line order from count 0 is sync, back porch, active, front porch; frames
// follow the same order in lines. Every output is a flop loaded from the
// decode of the next counter state, so outputs are coherent with the counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pix_en                   : pixel tick
//   o_hsync, o_vsync         : syncs at HSYNC_POL / VSYNC_POL when asserted
//   active                   : inside the active region
//   pos_x, pos_y             : active coordinate, 0 outside
//   pos_x_div, pos_y_div     : coordinates >> SCALE_SHIFT
//   line_start, frame_start  : one-clk pulses after a line / frame wrap
//   fetch_valid, fetch_x/y   : active/pos FETCH_LEAD ticks early
// Optional feature macro: VTG_FETCH_LEAD_EN (adds the fetch_* ports).
module video_timing_gen import video_timing_pkg::*; #(
  parameter int H_ACTIVE    = int'(VGA_H.active),
  parameter int H_FP        = int'(VGA_H.fp),
  parameter int H_SYNC      = int'(VGA_H.sync),
  parameter int H_BP        = int'(VGA_H.bp),
  parameter int V_ACTIVE    = int'(VGA_V.active),
  parameter int V_FP        = int'(VGA_V.fp),
  parameter int V_SYNC      = int'(VGA_V.sync),
  parameter int V_BP        = int'(VGA_V.bp),
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int SCALE_SHIFT = 0,
  parameter int FETCH_LEAD  = 2,
  parameter int CW          = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          active,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic [CW-1:0] pos_x_div,
  output logic [CW-1:0] pos_y_div,
  output logic          line_start,
  output logic          frame_start
`ifdef VTG_FETCH_LEAD_EN
  ,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y
`endif
);

  localparam axis_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                     sync: 16'(H_SYNC), bp: 16'(H_BP)};
  localparam axis_timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                     sync: 16'(V_SYNC), bp: 16'(V_BP)};
  localparam int H_TOTAL = axis_total(H_TIM);
  localparam int V_TOTAL = axis_total(V_TIM);

  if (clog2_total(H_TOTAL) > CW) begin : g_h_width_err
    $error("video_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (clog2_total(V_TOTAL) > CW) begin : g_v_width_err
    $error("video_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 4) begin : g_shift_err
    $error("video_timing_gen: SCALE_SHIFT must be 0..4");
  end
`ifdef VTG_FETCH_LEAD_EN
  if (FETCH_LEAD < 1 || FETCH_LEAD > H_SYNC + H_BP) begin : g_lead_err
    $error("video_timing_gen: FETCH_LEAD must be 1..H_SYNC+H_BP");
  end
`endif

  logic          h_end, v_end, h_wrap;
  logic          h_sync_d, v_sync_d, h_act_d, v_act_d;
  logic [CW-1:0] h_coord_d, v_coord_d;
  logic          h_lead_act_d, v_lead_act_d;
  logic [CW-1:0] h_lead_coord_d, v_lead_coord_d;

  assign h_wrap = pix_en & h_end;

  timing_axis #(.TIM(H_TIM), .CW(CW), .LEAD(FETCH_LEAD)) u_h_axis (
    .clk          (clk),
    .rst          (rst),
    .adv          (pix_en),
    .at_end       (h_end),
    .sync_d       (h_sync_d),
    .act_d        (h_act_d),
    .coord_d      (h_coord_d),
    .lead_act_d   (h_lead_act_d),
    .lead_coord_d (h_lead_coord_d)
  );

  timing_axis #(.TIM(V_TIM), .CW(CW), .LEAD(0)) u_v_axis (
    .clk          (clk),
    .rst          (rst),
    .adv          (h_wrap),
    .at_end       (v_end),
    .sync_d       (v_sync_d),
    .act_d        (v_act_d),
    .coord_d      (v_coord_d),
    .lead_act_d   (v_lead_act_d),
    .lead_coord_d (v_lead_coord_d)
  );

  logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic [CW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [CW-1:0] pos_x_div_q, pos_x_div_d, pos_y_div_q, pos_y_div_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = h_sync_d ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = v_sync_d ? VSYNC_POL : ~VSYNC_POL;
    active_d      = h_act_d & v_act_d;
    pos_x_d       = active_d ? h_coord_d : '0;
    pos_y_d       = active_d ? v_coord_d : '0;
    pos_x_div_d   = pos_x_d >> SCALE_SHIFT;
    pos_y_div_d   = pos_y_d >> SCALE_SHIFT;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= HSYNC_POL;
      vsync_q       <= VSYNC_POL;
      active_q      <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      pos_x_div_q   <= '0;
      pos_y_div_q   <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      pos_x_div_q   <= pos_x_div_d;
      pos_y_div_q   <= pos_y_div_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign active      = active_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign pos_x_div   = pos_x_div_q;
  assign pos_y_div   = pos_y_div_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VTG_FETCH_LEAD_EN
  // The lead stays on the current line, so the vertical part is the plain
  // active decode of this line.
  logic          fetch_valid_q, fetch_valid_d;
  logic [CW-1:0] fetch_x_q, fetch_x_d, fetch_y_q, fetch_y_d;

  always_comb begin
    fetch_valid_d = h_lead_act_d & v_act_d;
    fetch_x_d     = fetch_valid_d ? h_lead_coord_d : '0;
    fetch_y_d     = fetch_valid_d ? v_coord_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;

  logic unused_lead;
  assign unused_lead = ^{v_lead_act_d, v_lead_coord_d};
`else
  logic unused_lead;
  assign unused_lead = ^{h_lead_act_d, h_lead_coord_d, v_lead_act_d, v_lead_coord_d};
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int CW = 5, LEAD = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic          a_hsync, a_vsync, a_active, a_ls, a_fs;
  logic [CW-1:0] a_px, a_py, a_pxd, a_pyd;
  logic          b_hsync, b_vsync, b_active, b_ls, b_fs;
  logic [CW-1:0] b_px, b_py, b_pxd, b_pyd;
`ifdef VTG_FETCH_LEAD_EN
  logic          a_fv, b_fv;
  logic [CW-1:0] a_fx, a_fy, b_fx, b_fy;
`endif

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(0),
    .FETCH_LEAD(LEAD), .CW(CW)
  ) u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .active(a_active),
    .pos_x(a_px), .pos_y(a_py), .pos_x_div(a_pxd), .pos_y_div(a_pyd),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VTG_FETCH_LEAD_EN
    , .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_SHIFT(1),
    .FETCH_LEAD(LEAD), .CW(CW)
  ) u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .active(b_active),
    .pos_x(b_px), .pos_y(b_py), .pos_x_div(b_pxd), .pos_y_div(b_pyd),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VTG_FETCH_LEAD_EN
    , .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: position is a pure function of the number of pix_en
  // ticks since reset; adv records whether the last edge was a tick.
  int tick = 0;
  bit adv = 1'b0;

  function automatic int m_h(input int t);
    return t % HT;
  endfunction
  function automatic int m_v(input int t);
    return (t / HT) % VT;
  endfunction
  function automatic bit m_act(input int t);
    int h, v;
    h = m_h(t);
    v = m_v(t);
    return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
  endfunction
  function automatic int m_px(input int t);
    return m_act(t) ? m_h(t) - (HS + HB) : 0;
  endfunction
  function automatic int m_py(input int t);
    return m_act(t) ? m_v(t) - (VS + VB) : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d tick=%0d", tag, obs, exp, tick);
    end
  endtask

  task automatic check_all();
    bit ls, fs, hs, vs;
    ls = adv && (m_h(tick) == 0);
    fs = ls && (m_v(tick) == 0);
    hs = (m_h(tick) < HS);
    vs = (m_v(tick) < VS);
    chk("a_hsync", 32'(a_hsync), 32'(hs));
    chk("a_vsync", 32'(a_vsync), 32'(vs));
    chk("a_active", 32'(a_active), 32'(m_act(tick)));
    chk("a_pos_x", 32'(a_px), 32'(m_px(tick)));
    chk("a_pos_y", 32'(a_py), 32'(m_py(tick)));
    chk("a_pos_x_div", 32'(a_pxd), 32'(m_px(tick)));
    chk("a_pos_y_div", 32'(a_pyd), 32'(m_py(tick)));
    chk("a_line_start", 32'(a_ls), 32'(ls));
    chk("a_frame_start", 32'(a_fs), 32'(fs));
    chk("b_hsync", 32'(b_hsync), 32'(!hs));
    chk("b_vsync", 32'(b_vsync), 32'(!vs));
    chk("b_active", 32'(b_active), 32'(m_act(tick)));
    chk("b_pos_x", 32'(b_px), 32'(m_px(tick)));
    chk("b_pos_y", 32'(b_py), 32'(m_py(tick)));
    chk("b_pos_x_div", 32'(b_pxd), 32'(m_px(tick) >> 1));
    chk("b_pos_y_div", 32'(b_pyd), 32'(m_py(tick) >> 1));
    chk("b_line_start", 32'(b_ls), 32'(ls));
    chk("b_frame_start", 32'(b_fs), 32'(fs));
`ifdef VTG_FETCH_LEAD_EN
    chk("a_fetch_valid", 32'(a_fv), 32'(m_act(tick + LEAD)));
    chk("a_fetch_x", 32'(a_fx), 32'(m_px(tick + LEAD)));
    chk("a_fetch_y", 32'(a_fy), 32'(m_py(tick + LEAD)));
    chk("b_fetch_valid", 32'(b_fv), 32'(m_act(tick + LEAD)));
    chk("b_fetch_x", 32'(b_fx), 32'(m_px(tick + LEAD)));
    chk("b_fetch_y", 32'(b_fy), 32'(m_py(tick + LEAD)));
`endif
  endtask

  task automatic step(input bit r, input bit en);
    @(negedge clk);
    rst = r;
    pix_en = en;
    @(posedge clk);
    #1;
    if (r) begin
      tick = 0;
      adv = 1'b0;
    end else if (en) begin
      tick++;
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    check_all();
  endtask

  initial begin
    int first_fs, act_cnt, max_px, max_py, first_act_h, first_act_v;
    int last_fs, period;

    // Reset held 3 clks; reset must win whatever pix_en does.
    repeat (3) step(1'b1, 1'($urandom));

    // First full frame after release.
    first_fs = -1; act_cnt = 0; max_px = 0; max_py = 0;
    first_act_h = -1; first_act_v = -1;
    for (int i = 1; i <= FT; i++) begin
      step(1'b0, 1'b1);
      if (a_active === 1'b1) begin
        if (act_cnt == 0) begin
          first_act_h = m_h(tick);
          first_act_v = m_v(tick);
        end
        act_cnt++;
        if (int'(a_px) > max_px) max_px = int'(a_px);
        if (int'(a_py) > max_py) max_py = int'(a_py);
      end
      if (a_fs === 1'b1 && first_fs < 0) first_fs = i;
    end
    chk("first_frame_start_clk", 32'(first_fs), 32'(FT));
    chk("active_count", 32'(act_cnt), 32'(HA * VA));
    chk("max_pos_x", 32'(max_px), 32'(HA - 1));
    chk("max_pos_y", 32'(max_py), 32'(VA - 1));
    chk("first_active_h", 32'(first_act_h), 32'(HS + HB));
    chk("first_active_v", 32'(first_act_v), 32'(VS + VB));

    // pix_en toggling 1/0: frame period doubles.
    last_fs = -1; period = -1;
    for (int i = 1; i <= 4 * FT + 2; i++) begin
      step(1'b0, i[0]);
      if (a_fs === 1'b1) begin
        if (last_fs >= 0 && period < 0) period = i - last_fs;
        last_fs = i;
      end
    end
    chk("toggle_frame_period", 32'(period), 32'(2 * FT));

    // Random pix_en.
    for (int i = 0; i < 3 * FT; i++) step(1'b0, $urandom_range(0, 3) != 0);

    // Mid-frame reset with pix_en high, then next frame_start timing.
    step(1'b1, 1'b1);
    first_fs = -1;
    for (int i = 1; i <= FT + 2; i++) begin
      step(1'b0, 1'b1);
      if (a_fs === 1'b1 && first_fs < 0) first_fs = i;
    end
    chk("frame_start_after_reset", 32'(first_fs), 32'(FT));

    // Random pix_en with sporadic resets.
    for (int i = 0; i < 3 * FT; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
